// File: rtl/bp_btb_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_btb_param_pkg
// Description : Shared defaults, counter-op encoding and helpers for the
//               parametrised BTB branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_btb_param_pkg;

    localparam int BTB_W_DEFAULT       = 32;
    localparam int BTB_ENTRIES_DEFAULT = 16;
    localparam int BTB_TAG_W_DEFAULT   = 8;
    localparam int BTB_CTR_W_DEFAULT   = 2;

    // Operation requested from the saturating counter on the update path.
    typedef enum logic [1:0] {
        CTR_HOLD = 2'd0,
        CTR_INC  = 2'd1,
        CTR_DEC  = 2'd2
    } ctr_op_e;

    // Weakly-taken allocation value: 2^(ctr_w-1).
    function automatic int ctr_weak_taken(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

    // Lowest PC bit of the tag field for a given index width.
    function automatic int pc_tag_lsb(input int idx_w);
        return idx_w + 2;
    endfunction

endpackage : bp_btb_param_pkg
`default_nettype wire

// File: rtl/bp_btb_param_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Combinational next-value logic for a saturating up/down
//               counter; storage lives in the instantiating block.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import bp_btb_param_pkg::*;
#(
    parameter int CTR_W = BTB_CTR_W_DEFAULT
) (
    input  ctr_op_e          op,
    input  logic [CTR_W-1:0] cur,
    output logic [CTR_W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (op)
            CTR_INC: begin
                if (cur != {CTR_W{1'b1}}) begin
                    nxt = cur + CTR_W'(1);
                end
            end
            CTR_DEC: begin
                if (cur != {CTR_W{1'b0}}) begin
                    nxt = cur - CTR_W'(1);
                end
            end
            default: begin
                nxt = cur;
            end
        endcase
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/bp_btb_param.sv
`default_nettype none
// ============================================================================
// Module      : bp_btb_param
// Description : Direct-mapped BTB with per-entry saturating direction
//               counters; zero-latency lookup, registered training.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_btb_param
    import bp_btb_param_pkg::*;
#(
    parameter int W       = BTB_W_DEFAULT,
    parameter int ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter int TAG_W   = BTB_TAG_W_DEFAULT,
    parameter int CTR_W   = BTB_CTR_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lookup_pc,
    output logic         predict_j_taken,
    output logic [W-1:0] predict_addr,
    output logic         predict_hit,
    input  logic         upd,
    input  logic [W-1:0] upd_src_pc,
    input  logic         upd_taken,
    input  logic [W-1:0] upd_target,
    input  logic         inv_all
);

    localparam int c_idx_w   = $clog2(ENTRIES);
    localparam int c_tag_lsb = pc_tag_lsb(c_idx_w);
    localparam int c_tag_msb = c_tag_lsb + TAG_W - 1;
    localparam logic [CTR_W-1:0] c_ctr_weak = CTR_W'(ctr_weak_taken(CTR_W));

    // Table state; tags and targets carry no reset, valid gates them.
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [W-3:0]       r_target [ENTRIES];
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];

    logic [c_idx_w-1:0] w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;

    logic [c_idx_w-1:0] w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    logic               w_upd_en;
    logic               w_write_target;
    ctr_op_e            w_ctr_op;
    logic [CTR_W-1:0]   w_ctr_nxt;
    logic               w_unused_bits;

    assign w_lk_idx = lookup_pc[c_idx_w+1:2];
    assign w_lk_tag = lookup_pc[c_tag_msb:c_tag_lsb];

    assign w_lk_hit        = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign predict_hit     = w_lk_hit;
    assign predict_j_taken = w_lk_hit && r_ctr[w_lk_idx][CTR_W-1];
    assign predict_addr    = predict_j_taken ? {r_target[w_lk_idx], 2'b00}
                                             : lookup_pc + W'(4);

    assign w_upd_idx = upd_src_pc[c_idx_w+1:2];
    assign w_upd_tag = upd_src_pc[c_tag_msb:c_tag_lsb];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    // inv_all drops any coincident update.
    assign w_upd_en = upd && !inv_all;

    // Taken outcomes rewrite the target on a hit and allocate on a miss.
    assign w_write_target = rst && w_upd_en && upd_taken;

    always_comb begin
        w_ctr_op = CTR_HOLD;
        if (w_upd_hit) begin
            w_ctr_op = upd_taken ? CTR_INC : CTR_DEC;
        end
    end

    sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .op  (w_ctr_op),
        .cur (r_ctr[w_upd_idx]),
        .nxt (w_ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= '0;
            end
        end else if (inv_all) begin
            r_valid <= '0;
        end else if (upd) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= w_ctr_nxt;
            end else if (upd_taken) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_ctr[w_upd_idx]   <= c_ctr_weak;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write_target) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target[W-1:2];
        end
    end

    // Bits of the update PC/target that never reach the table.
    assign w_unused_bits = ^{upd_src_pc, upd_target[1:0]};

endmodule : bp_btb_param
`default_nettype wire
